// File: rtl/led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_gen
// Purpose  : Multi-channel LED pattern generator (off / blink / chase / breathe)
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_gen #(
  parameter int                     NUM_LEDS   = 7,
  parameter int                     PRESCALE   = 12000,
  parameter int                     STEP_TICKS = 250,
  parameter int                     PWM_BITS   = 8,
  parameter logic [NUM_LEDS-1:0]    LED_INV    = 7'b0000011
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  output logic [NUM_LEDS-1:0] led,
  output logic                tick
);

  localparam int c_pre_w  = $clog2(PRESCALE);
  localparam int c_step_w = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int c_pos_w  = $clog2(NUM_LEDS);

  localparam logic [c_pre_w-1:0]  c_pre_last  = c_pre_w'(PRESCALE - 1);
  localparam logic [c_pre_w-1:0]  c_pre_one   = c_pre_w'(1);
  localparam logic [c_step_w-1:0] c_step_last = c_step_w'(STEP_TICKS - 1);
  localparam logic [c_step_w-1:0] c_step_one  = c_step_w'(1);
  localparam logic [c_pos_w-1:0]  c_pos_last  = c_pos_w'(NUM_LEDS - 1);
  localparam logic [c_pos_w-1:0]  c_pos_one   = c_pos_w'(1);
  localparam logic [PWM_BITS-1:0] c_duty_one  = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] c_duty_top1 = {{(PWM_BITS-1){1'b1}}, 1'b0};
  localparam logic [NUM_LEDS-1:0] c_led_one   = NUM_LEDS'(1);

  localparam logic [1:0] c_mode_off     = 2'd0;
  localparam logic [1:0] c_mode_blink   = 2'd1;
  localparam logic [1:0] c_mode_chase   = 2'd2;
  localparam logic [1:0] c_mode_breathe = 2'd3;

  logic [c_pre_w-1:0]  r_pre_cnt;
  logic [c_step_w-1:0] r_step_cnt, w_step_nxt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [1:0]          r_mode_q;
  logic                r_blink_st, w_blink_nxt;
  logic [c_pos_w-1:0]  r_pos, w_pos_nxt;
  logic [PWM_BITS-1:0] r_duty, w_duty_nxt;
  logic                r_dir_down, w_dir_nxt;
  logic                w_tick, w_step_evt, w_mode_chg;
  logic [NUM_LEDS-1:0] w_raw;

  assign w_tick     = (r_pre_cnt == c_pre_last);
  assign w_step_evt = w_tick && (r_step_cnt == c_step_last);
  assign w_mode_chg = (mode != r_mode_q);
  assign tick       = w_tick;

  // State register: free-running counters are never disturbed by mode changes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt  <= '0;
      r_pwm_cnt  <= '0;
      r_mode_q   <= c_mode_off;
      r_step_cnt <= '0;
      r_blink_st <= 1'b0;
      r_pos      <= '0;
      r_duty     <= '0;
      r_dir_down <= 1'b0;
      led        <= LED_INV;
    end else begin
      r_pre_cnt  <= w_tick ? '0 : r_pre_cnt + c_pre_one;
      r_pwm_cnt  <= r_pwm_cnt + c_duty_one;
      r_mode_q   <= mode;
      r_step_cnt <= w_step_nxt;
      r_blink_st <= w_blink_nxt;
      r_pos      <= w_pos_nxt;
      r_duty     <= w_duty_nxt;
      r_dir_down <= w_dir_nxt;
      led        <= w_raw ^ LED_INV;
    end
  end

  // Next pattern state; a mode change clears state even on a tick/step cycle
  always_comb begin
    w_step_nxt  = r_step_cnt;
    w_blink_nxt = r_blink_st;
    w_pos_nxt   = r_pos;
    w_duty_nxt  = r_duty;
    w_dir_nxt   = r_dir_down;
    if (w_mode_chg) begin
      w_step_nxt  = '0;
      w_blink_nxt = 1'b0;
      w_pos_nxt   = '0;
      w_duty_nxt  = '0;
      w_dir_nxt   = 1'b0;
    end else if (w_tick) begin
      if (w_step_evt) begin
        w_step_nxt  = '0;
        w_blink_nxt = ~r_blink_st;
        w_pos_nxt   = (r_pos == c_pos_last) ? '0 : r_pos + c_pos_one;
      end else begin
        w_step_nxt  = r_step_cnt + c_step_one;
      end
      // Triangle walk: direction flips on arrival so each extreme lasts one tick
      if (!r_dir_down) begin
        w_duty_nxt = r_duty + c_duty_one;
        if (r_duty == c_duty_top1) w_dir_nxt = 1'b1;
      end else begin
        w_duty_nxt = r_duty - c_duty_one;
        if (r_duty == c_duty_one) w_dir_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    w_raw = '0;
    case (r_mode_q)
      c_mode_off:     w_raw = '0;
      c_mode_blink:   w_raw = {NUM_LEDS{r_blink_st}};
      c_mode_chase:   w_raw = c_led_one << r_pos;
      c_mode_breathe: w_raw = {NUM_LEDS{r_pwm_cnt < r_duty}};
      default:        w_raw = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_led_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pattern_gen
// Purpose  : Self-checking bench for led_pattern_gen against a tick-count model
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pattern_gen;

  localparam int NL   = 7;
  localparam int P    = 4;
  localparam int ST   = 2;
  localparam int PB   = 3;
  localparam int PMAX = (1 << PB) - 1;
  localparam logic [NL-1:0] INV = 7'b0000011;

  logic          clk;
  logic          rst_n;
  logic [1:0]    mode;
  logic [NL-1:0] led;
  logic          tick;

  int total = 0;
  int bad   = 0;

  // Model: pattern derived from ticks counted since the last state clear
  int            m_ticks, m_pre, m_pwm, m_mq;
  logic [NL-1:0] m_led;
  logic          m_tick;

  led_pattern_gen #(
    .NUM_LEDS(NL), .PRESCALE(P), .STEP_TICKS(ST), .PWM_BITS(PB), .LED_INV(INV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .led(led), .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NL-1:0] raw_of(int mq, int t, int pwm);
    int tt, d;
    case (mq)
      1: return (((t / ST) % 2) == 1) ? '1 : '0;
      2: return NL'(1 << ((t / ST) % NL));
      3: begin
        tt = t % (2 * PMAX);
        d  = (tt <= PMAX) ? tt : 2 * PMAX - tt;
        return (pwm < d) ? '1 : '0;
      end
      default: return '0;
    endcase
  endfunction

  function automatic int duty_of(int t);
    int tt;
    tt = t % (2 * PMAX);
    return (tt <= PMAX) ? tt : 2 * PMAX - tt;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_pre = 0; m_pwm = 0; m_mq = 0; m_ticks = 0;
      m_led = INV;
    end else begin
      m_led = raw_of(m_mq, m_ticks, m_pwm) ^ INV;
      if (int'(mode) != m_mq) begin
        m_mq    = int'(mode);
        m_ticks = 0;
      end else if (m_pre == P - 1) begin
        m_ticks++;
      end
      m_pre = (m_pre + 1) % P;
      m_pwm = (m_pwm + 1) % (1 << PB);
    end
    m_tick = (m_pre == P - 1);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("led", 32'(led), 32'(m_led));
    chk("tick", 32'(tick), 32'(m_tick));
  endtask

  initial begin
    bit found;
    int first_tick;

    rst_n = 1'b0;
    mode  = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_led", 32'(led), 32'(INV));
      chk("rst_tick", 32'(tick), 32'd0);
    end

    // First tick strobe is seen after the third post-release edge, then every P
    rst_n = 1'b1;
    first_tick = -1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (tick && first_tick < 0) first_tick = i;
    end
    chk("first_tick_edge", 32'(first_tick), 32'(P - 1));

    for (int i = 0; i < 30; i++) step();

    mode = 2'd2;
    step();
    step();
    chk("chase_start", 32'(led), 32'(7'b0000001 ^ INV));
    for (int i = 0; i < 8; i++) step();
    chk("chase_step1", 32'(led), 32'(7'b0000010 ^ INV));
    for (int i = 0; i < 60; i++) step();

    mode = 2'd3;
    for (int i = 0; i < 130; i++) step();

    // Mode change exactly on a chase step event with pos=3
    mode = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m_mq == 2 && ((m_ticks / ST) % NL) == 3 && (m_ticks % ST) == ST - 1 && m_pre == P - 1)
        found = 1'b1;
      else
        step();
    end
    chk("found_chase_pos3", 32'(found), 32'd1);
    mode = 2'd1;
    step();
    step();
    chk("chg_at_step_led", 32'(led), 32'(INV));
    for (int i = 0; i < 20; i++) step();

    // Reset while breathing downward through duty 5
    mode = 2'd3;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_mq == 3 && (m_ticks % (2 * PMAX)) == 9 && duty_of(m_ticks) == 5)
        found = 1'b1;
      else
        step();
    end
    chk("found_duty5_down", 32'(found), 32'd1);
    rst_n = 1'b0;
    step();
    chk("midrst_led", 32'(led), 32'(INV));
    rst_n = 1'b1;
    for (int i = 0; i < 70; i++) step();

    // Random mode churn including toggle-and-restore and occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
